// File: rtl/aes_spi_slave_ctrl_if.sv
// Bus bundle between the serial master / AES core side and aes_spi_slave_ctrl.
// NK sets the key width (NK*32 bits) and must match the controller's NK.
interface aes_spi_slave_ctrl_if #(
    parameter int NK = 4
);
    logic              cs_n;
    logic              simo;
    logic              mode;
    logic              somi;
    logic              core_start;
    logic              core_mode;
    logic [127:0]      core_data;
    logic [NK*32-1:0]  core_key;
    logic              core_done;
    logic [127:0]      core_result;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  cs_n, simo, mode, core_done, core_result,
        output somi, core_start, core_mode, core_data, core_key, busy, frame_err
    );

    modport master (
        output cs_n, simo, mode, core_done, core_result,
        input  somi, core_start, core_mode, core_data, core_key, busy, frame_err
    );
endinterface

// File: rtl/aes_spi_slave_ctrl.sv
// Serial front end for an AES core: receives a 128-bit block followed by an
// NK*32-bit key (LSB first), starts the core, and shifts the result back out.
// Optional feature: define AES_SPI_KEY_RETAIN_EN to allow a data-only frame to
// reuse the previously received key.
module aes_spi_slave_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_spi_slave_ctrl_if.slave  bus
);

    localparam int         KEY_BITS  = NK * 32;
    localparam logic [8:0] DATA_LAST = 9'd127;
    localparam logic [8:0] KEY_LAST  = 9'(KEY_BITS - 1);

    // Reject parameter sets the AES core cannot run.
    if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_param_check
        $error("aes_spi_slave_ctrl: illegal NK/NR combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_DATA   = 3'd1,
        ST_RX_KEY    = 3'd2,
        ST_WAIT_CORE = 3'd3,
        ST_TX        = 3'd4
    } state_t;

    state_t                state_r;
    logic [8:0]            bit_cnt_r;
    logic [127:0]          data_sr_r;
    logic [KEY_BITS-1:0]   key_sr_r;
    logic [127:0]          tx_r;
    logic                  key_valid_r;
    logic                  core_start_r;
    logic                  frame_err_r;
    logic                  core_mode_r;

    // Frame sequencer: receive, hand off to the core, transmit the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 9'd0;
            data_sr_r    <= 128'd0;
            key_sr_r     <= '0;
            tx_r         <= 128'd0;
            key_valid_r  <= 1'b0;
            core_start_r <= 1'b0;
            frame_err_r  <= 1'b0;
            core_mode_r  <= 1'b0;
        end else begin
            core_start_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!bus.cs_n) begin
                        data_sr_r   <= {bus.simo, data_sr_r[127:1]};
                        core_mode_r <= bus.mode;
                        bit_cnt_r   <= 9'd1;
                        state_r     <= ST_RX_DATA;
                    end
                end
                ST_RX_DATA: begin
                    if (!bus.cs_n) begin
                        data_sr_r <= {bus.simo, data_sr_r[127:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 9'd0;
                            state_r   <= ST_RX_KEY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 9'd1;
                        end
                    end else begin
                        // Frame ended before the block was complete.
                        frame_err_r <= 1'b1;
                        bit_cnt_r   <= 9'd0;
                        state_r     <= ST_IDLE;
`ifndef AES_SPI_KEY_RETAIN_EN
                        key_valid_r <= 1'b0;
`endif
                    end
                end
                ST_RX_KEY: begin
                    if (!bus.cs_n) begin
                        key_sr_r <= {bus.simo, key_sr_r[KEY_BITS-1:1]};
                        if (bit_cnt_r == KEY_LAST) begin
                            key_valid_r  <= 1'b1;
                            bit_cnt_r    <= 9'd0;
                            core_start_r <= 1'b1;
                            state_r      <= ST_WAIT_CORE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 9'd1;
                        end
                    end else begin
`ifdef AES_SPI_KEY_RETAIN_EN
                        // Data-only frame: run with the key already held.
                        if (bit_cnt_r == 9'd0 && key_valid_r) begin
                            core_start_r <= 1'b1;
                            state_r      <= ST_WAIT_CORE;
                        end else begin
                            frame_err_r <= 1'b1;
                            bit_cnt_r   <= 9'd0;
                            state_r     <= ST_IDLE;
                        end
`else
                        frame_err_r <= 1'b1;
                        key_valid_r <= 1'b0;
                        bit_cnt_r   <= 9'd0;
                        state_r     <= ST_IDLE;
`endif
                    end
                end
                ST_WAIT_CORE: begin
                    // Only entered with a valid key; the guard keeps a stray
                    // result from being transmitted if that ever breaks.
                    if (bus.core_done && key_valid_r) begin
                        tx_r      <= bus.core_result;
                        bit_cnt_r <= 9'd0;
                        state_r   <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (!bus.cs_n) begin
                        tx_r <= {1'b0, tx_r[127:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 9'd0;
                            state_r   <= ST_IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 9'd1;
                        end
                    end
                end
                default: begin
                    bit_cnt_r <= 9'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.somi       = (state_r == ST_TX) ? tx_r[0] : 1'b0;
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.core_start = core_start_r;
    assign bus.core_mode  = core_mode_r;
    assign bus.core_data  = data_sr_r;
    assign bus.core_key   = key_sr_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_aes_spi_slave_ctrl.sv
// Bench for aes_spi_slave_ctrl: NK=4 instance checked every cycle against a
// frame-level model, NK=8 instance checked with directed expectations.
module tb_aes_spi_slave_ctrl;

    localparam logic [127:0] DATA1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DATA2 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] KEY2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RES2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] DATA8 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [255:0] KEY8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RES8  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    aes_spi_slave_ctrl_if #(.NK(4)) bus4 ();
    aes_spi_slave_ctrl_if #(.NK(8)) bus8 ();

    aes_spi_slave_ctrl #(.NK(4), .NR(10)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    aes_spi_slave_ctrl #(.NK(8), .NR(14)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- frame-level model of the NK=4 instance ----------------
    // phase: 0 idle, 1 receiving, 2 waiting for core, 3 sending result
    int           m_phase;
    int           m_cnt;
    logic [255:0] m_bits;
    logic         m_mode;
    logic         m_kv;
    logic         m_start;
    logic         m_err;
    logic [127:0] m_res;
    logic [127:0] exp_data;
    logic [127:0] exp_key;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_cnt <= 0; m_bits <= '0; m_mode <= 1'b0; m_kv <= 1'b0;
            m_start <= 1'b0; m_err <= 1'b0; m_res <= '0; exp_data <= '0; exp_key <= '0;
        end else begin
            m_start <= 1'b0;
            m_err   <= 1'b0;
            case (m_phase)
                0: if (!bus4.cs_n) begin
                    m_bits[0] <= bus4.simo; m_cnt <= 1; m_mode <= bus4.mode; m_phase <= 1;
                end
                1: if (!bus4.cs_n) begin
                    m_bits[m_cnt] <= bus4.simo;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 255) begin
                        m_kv <= 1'b1; m_start <= 1'b1; m_phase <= 2;
                        exp_data <= m_bits[127:0];
                        exp_key  <= {bus4.simo, m_bits[254:128]};
                    end
                end else begin
`ifdef AES_SPI_KEY_RETAIN_EN
                    if (m_cnt == 128 && m_kv) begin
                        m_start <= 1'b1; m_phase <= 2; exp_data <= m_bits[127:0];
                    end else begin
                        m_err <= 1'b1; m_phase <= 0;
                    end
`else
                    m_err <= 1'b1; m_phase <= 0; m_kv <= 1'b0;
`endif
                end
                2: if (bus4.core_done) begin
                    m_res <= bus4.core_result; m_cnt <= 0; m_phase <= 3;
                end
                3: if (!bus4.cs_n) begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 127) m_phase <= 0;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison of the NK=4 instance against the model.
    always @(negedge clk) begin
        chk("busy", bus4.busy, m_phase != 0);
        chk("core_start", bus4.core_start, m_start);
        chk("frame_err", bus4.frame_err, m_err);
        chk("core_mode", bus4.core_mode, m_mode);
        chk("somi", bus4.somi, (m_phase == 3) ? m_res[m_cnt] : 1'b0);
        if (m_phase == 2) begin
            chk("core_data", bus4.core_data, exp_data);
            chk("core_key", bus4.core_key, exp_key);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit4(input logic b, input logic m);
        @(posedge clk); #2;
        bus4.cs_n = 1'b0; bus4.simo = b; bus4.mode = m;
    endtask

    task automatic idle4(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            bus4.cs_n = 1'b1; bus4.simo = 1'b0;
        end
    endtask

    task automatic send_data4(input logic [127:0] d, input logic m);
        for (int i = 0; i < 128; i++) send_bit4(d[i], m);
    endtask

    task automatic send_key4(input logic [127:0] k, input logic m);
        for (int i = 0; i < 128; i++) send_bit4(k[i], m);
    endtask

    task automatic done4(input logic [127:0] r);
        @(posedge clk); #2; bus4.core_done = 1'b1; bus4.core_result = r;
        @(posedge clk); #2; bus4.core_done = 1'b0; bus4.core_result = '0;
    endtask

    task automatic drain4(input int n, output logic [127:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2; bus4.cs_n = 1'b0;
            @(negedge clk); got[i] = bus4.somi;
        end
    endtask

    logic [127:0] got;

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        bus4.cs_n = 1'b1; bus4.simo = 1'b0; bus4.mode = 1'b0; bus4.core_done = 1'b0; bus4.core_result = '0;
        bus8.cs_n = 1'b1; bus8.simo = 1'b0; bus8.mode = 1'b0; bus8.core_done = 1'b0; bus8.core_result = '0;
        repeat (3) @(posedge clk);

        // Reset state of both instances.
        @(negedge clk);
        chk("rst busy4", bus4.busy, 1'b0);
        chk("rst somi4", bus4.somi, 1'b0);
        chk("rst mode4", bus4.core_mode, 1'b0);
        chk("rst data4", bus4.core_data, 128'd0);
        chk("rst key8", bus8.core_key, 256'd0);
        chk("rst err8", bus8.frame_err, 1'b0);
        @(posedge clk); #2; rst_n = 1'b1;

        // core_done while idle is ignored.
        done4(RES2);
        @(negedge clk); chk("idle core_done busy", bus4.busy, 1'b0);

        // Reference encrypt frame.
        send_data4(DATA1, 1'b0);
        send_key4(KEY1, 1'b0);
        idle4(1);
        @(negedge clk);
        chk("f1 core_start", bus4.core_start, 1'b1);
        chk("f1 core_data", bus4.core_data, DATA1);
        chk("f1 core_key", bus4.core_key, KEY1);
        chk("f1 core_mode", bus4.core_mode, 1'b0);
        done4(RES1);
        drain4(128, got);
        idle4(1);
        chk("f1 result", got, RES1);
        @(negedge clk); chk("f1 idle", bus4.busy, 1'b0);

        // Data-only frame right after a full frame.
        send_data4(DATA2, 1'b1);
        idle4(1);
        @(negedge clk);
        @(negedge clk);
`ifdef AES_SPI_KEY_RETAIN_EN
        chk("retain start", bus4.core_start, 1'b1);
        chk("retain key", bus4.core_key, KEY1);
        chk("retain data", bus4.core_data, DATA2);
        done4(RES2);
        drain4(128, got);
        idle4(1);
        chk("retain result", got, RES2);
`else
        chk("dataonly err", bus4.frame_err, 1'b1);
        chk("dataonly start", bus4.core_start, 1'b0);
        chk("dataonly busy", bus4.busy, 1'b0);
`endif
        idle4(2);

        // Abort after 60 data bits.
        for (int i = 0; i < 60; i++) send_bit4(DATA2[i], 1'b0);
        idle4(1);
        @(negedge clk); chk("abort err early", bus4.frame_err, 1'b0);
        @(negedge clk);
        chk("abort err", bus4.frame_err, 1'b1);
        chk("abort busy", bus4.busy, 1'b0);
        @(negedge clk); chk("abort err once", bus4.frame_err, 1'b0);

        // Decrypt frame with a different key and result, sent with gaps.
        send_data4(DATA2, 1'b1);
        send_key4(KEY2, 1'b1);
        idle4(3);
        done4(RES2);
        drain4(128, got);
        idle4(1);
        chk("f2 result", got, RES2);

        // Reset in the middle of transmission.
        send_data4(DATA1, 1'b0);
        send_key4(KEY1, 1'b0);
        idle4(1);
        done4(RES1);
        drain4(40, got);
        @(posedge clk); #2; rst_n = 1'b0; bus4.cs_n = 1'b1;
        #1;
        chk("midtx rst somi", bus4.somi, 1'b0);
        chk("midtx rst busy", bus4.busy, 1'b0);
        chk("midtx partial", got[39:0], RES1[39:0]);
        @(posedge clk); #2; rst_n = 1'b1;
        done4(RES2);
        @(negedge clk); chk("post rst core_done", bus4.busy, 1'b0);
        idle4(2);

        // NK=8 decrypt frame: 128 data bits then 256 key bits.
        for (int i = 0; i < 384; i++) begin
            @(posedge clk); #2;
            bus8.cs_n = 1'b0; bus8.mode = 1'b1;
            bus8.simo = (i < 128) ? DATA8[i] : KEY8[i-128];
            if (i == 383) begin
                @(negedge clk); chk("nk8 start early", bus8.core_start, 1'b0);
            end
        end
        @(posedge clk); #2; bus8.cs_n = 1'b1;
        @(negedge clk);
        chk("nk8 core_start", bus8.core_start, 1'b1);
        chk("nk8 core_key", bus8.core_key, KEY8);
        chk("nk8 core_data", bus8.core_data, DATA8);
        chk("nk8 core_mode", bus8.core_mode, 1'b1);
        @(negedge clk); chk("nk8 start once", bus8.core_start, 1'b0);
        @(posedge clk); #2; bus8.core_done = 1'b1; bus8.core_result = RES8;
        @(posedge clk); #2; bus8.core_done = 1'b0;
        got = '0;
        for (int i = 0; i < 128; i++) begin
            @(posedge clk); #2; bus8.cs_n = 1'b0;
            @(negedge clk); got[i] = bus8.somi;
        end
        @(posedge clk); #2; bus8.cs_n = 1'b1;
        chk("nk8 result", got, RES8);
        @(negedge clk);
        chk("nk8 idle", bus8.busy, 1'b0);
        chk("nk8 somi idle", bus8.somi, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
